aes_key_expand: RTL
===================

# aes_key_expand

Iterative AES key-schedule generator that sits directly upstream of `aes_build`. It expands a 128-, 192- or 256-bit cipher key into round keys at one 32-bit schedule word per cycle. It then raises `ready`, which `aes_build` takes as "plain text and round keys valid". Round keys are presented with the first round key (the cipher key itself) at index [15].

## Interface
Parameters: none. Key length is selected at run time by `key_size`.

Ports:
- `eph1`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to expand `true_key`; sampled on posedge.
- `key_size`  in  2  key length: 00 = 128-bit, 01 = 192-bit, 10 or 11 = 256-bit; captured when `start` is accepted.
- `true_key`  in  256  cipher key, left-aligned: 128-bit key in [255:128], 192-bit key in [255:64]; unused low bits ignored; captured when `start` is accepted.
- `key_words`  out  [15:1][127:0]  round keys; [15] = round 0.
- `ready`  out  1  high once the full schedule is written; stays high until the next accepted `start` or `reset`.

## Operation
- Nk = 4/6/8 and total words T = 44/52/60 for 128/192/256-bit keys.
- Schedule words w[0..59], 32 bits each, are held in registers.
- Round key r maps as key_words[15-r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
- Entries beyond T/4 read zero: [4:1] for 128-bit keys, [2:1] for 192-bit keys.
- FSM states: IDLE, EXPAND, DONE.
- IDLE or DONE with `start`=1:
  - capture `key_size`;
  - write w[0..Nk-1] from `true_key` (w[0] = [255:224]);
  - clear w[Nk..59] to zero;
  - set index i = Nk, position p = 0, rcon = 8'h01;
  - clear `ready`; go to EXPAND.
- EXPAND, one word per cycle: w[i] = w[i-1] ^ w[i-Nk] after the following transform of w[i-1]:
  - p == 0: SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon = xtime(rcon);
  - Nk == 8 and p == 4: SubWord(w[i-1]);
  - otherwise: w[i-1] unchanged.
- Counter and rcon rules in EXPAND:
  - p wraps at Nk-1;
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00), 8-bit result;
  - when i == T-1 is written: set `ready` and go to DONE.
- `start` while in EXPAND is ignored; the current expansion completes.
- DONE holds all words and keeps `ready`=1 indefinitely.
- `key_words` is driven straight from the word registers and may change during EXPAND. Consumers sample it only while `ready`=1.

## Timing
- Reset values: all w = 0, so `key_words` = 0; `ready` = 0; state IDLE; i = 0; p = 0; rcon = 8'h01.
- `reset` overrides everything, including mid-EXPAND and a simultaneous `start`.
- `start` accepted at posedge t: w[0..Nk-1] are visible after t.
- `ready` rises after posedge t+(T-Nk): t+40, t+46 or t+52.
- The last word and `ready` appear on the same edge, so `ready`=1 guarantees the complete schedule.
- A restart from DONE drops `ready` on the accepting edge. A new key is never mixed with old round keys under `ready`=1.
- `start` held high for several cycles counts as one request. Re-acceptance is possible only from DONE.

## Structure
- Shared package `aes_kx_pkg`:
  - key-size encodings;
  - Nk/T lookup function;
  - xtime function;
  - state enum {IDLE, EXPAND, DONE}.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, shared with `aes_build`. Instantiated 4× for SubWord.
- Registers use the `rregs` library with `eph1`.

## Test plan
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c, `start` one cycle:
  - w[4] = a0fafe17;
  - key_words[5] = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - key_words[4:1] = 0;
  - `ready` first high 40 cycles after the accepting edge.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w[6] = fe0c91f7;
  - w[51] = 01002202;
  - `ready` at +46.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, `key_size`=11:
  - w[8] = 9ba35411;
  - w[59] = 706c631e;
  - `ready` at +52.
- Key 000102030405060708090a0b0c0d0e0f, then restart from DONE with 2b7e…4f3c:
  - first run gives key_words[5] = 13111d7fe3944a17f307a78b4d2b30c5;
  - `ready` drops on the restart edge and never rises with mixed keys.
- `start` pulsed mid-EXPAND: ignored, first-key result unchanged.
- `reset` asserted at cycle 20 of EXPAND: all outputs 0 next cycle, state IDLE; a subsequent `start` expands correctly.

Source files
------------

// File: rtl/aes_kx_pkg.sv
// Shared definitions for the AES key-schedule generator: key-size encodings,
// schedule-length lookups, GF(2^8) helpers and the FSM state type.
package aes_kx_pkg;

    typedef enum logic [1:0] {
        KS_128 = 2'b00,
        KS_192 = 2'b01,
        KS_256 = 2'b10
    } key_size_e;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_e;

    localparam int unsigned NUM_WORDS = 60;

    // 2'b11 is treated as a 256-bit key
    function automatic logic [3:0] nk_of(input logic [1:0] ks);
        case (ks)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [5:0] total_of(input logic [1:0] ks);
        case (ks)
            2'b00:   return 6'd44;
            2'b01:   return 6'd52;
            default: return 6'd60;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int unsigned k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request/result bundle between the key-schedule generator and its consumer.
interface aes_key_expand_if;
    logic               start;
    logic [1:0]         key_size;
    logic [255:0]       true_key;
    logic [15:1][127:0] key_words;
    logic               ready;

    modport master (output start, key_size, true_key, input key_words, ready);
    modport slave  (input start, key_size, true_key, output key_words, ready);
endinterface

// File: rtl/aes_key_expand_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) then the
// affine transform.
module aes_sbox
    import aes_kx_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] y;
    logic [7:0] inv;

    // x^254 == x^-1 (and maps 0 to 0): build x^127 by square-and-multiply, square once more
    always_comb begin
        y = in_byte;
        for (int unsigned k = 0; k < 6; k++) begin
            y = gf_mul(gf_mul(y, y), in_byte);
        end
        inv = gf_mul(y, y);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion for 128/192/256-bit keys, one schedule word per
// cycle; ready marks a complete, consistent set of round keys.
module aes_key_expand
    import aes_kx_pkg::*;
(
    input  logic             eph1,
    input  logic             reset,
    aes_key_expand_if.slave  kx
);

    state_e      state_q, state_d;
    logic [31:0] w_q [NUM_WORDS];
    logic [31:0] w_d [NUM_WORDS];
    logic [5:0]  i_q, i_d;
    logic [2:0]  p_q, p_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [1:0]  ks_q, ks_d;
    logic        ready_q, ready_d;

    logic [3:0]  nk, nk_new;
    logic [5:0]  total;
    logic [31:0] prev, back, sub_in, sub_out, temp;

    assign nk     = nk_of(ks_q);
    assign total  = total_of(ks_q);
    assign nk_new = nk_of(kx.key_size);
    assign prev   = w_q[i_q - 6'd1];
    assign back   = w_q[i_q - {2'b00, nk}];
    assign sub_in = (p_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        if (p_q == 3'd0)                 temp = sub_out ^ {rcon_q, 24'h0};
        else if (nk == 4'd8 && p_q == 3'd4) temp = sub_out;
        else                             temp = prev;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        p_d     = p_q;
        rcon_d  = rcon_q;
        ks_d    = ks_q;
        ready_d = ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (kx.start) begin
                    ks_d = kx.key_size;
                    for (int unsigned k = 0; k < NUM_WORDS; k++) w_d[k] = '0;
                    for (int unsigned k = 0; k < 8; k++) begin
                        if (k < 32'(nk_new)) w_d[k] = kx.true_key[255 - 32*k -: 32];
                    end
                    i_d     = {2'b00, nk_new};
                    p_d     = '0;
                    rcon_d  = 8'h01;
                    ready_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_d[i_q] = temp ^ back;
                i_d      = i_q + 6'd1;
                p_d      = ({1'b0, p_q} == nk - 4'd1) ? 3'd0 : p_q + 3'd1;
                if (p_q == 3'd0) rcon_d = xtime(rcon_q);
                if (i_q == total - 6'd1) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < NUM_WORDS; k++) w_q[k] <= '0;
            i_q     <= '0;
            p_q     <= '0;
            rcon_q  <= 8'h01;
            ks_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            i_q     <= i_d;
            p_q     <= p_d;
            rcon_q  <= rcon_d;
            ks_q    <= ks_d;
            ready_q <= ready_d;
        end
    end

    // round r occupies key_words[15-r]; unused tail words stay cleared, so short keys read zero there
    always_comb begin
        for (int unsigned r = 0; r < 15; r++) begin
            kx.key_words[15 - r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
        end
    end

    assign kx.ready = ready_q;

endmodule
